will_keen_solitaire: RTL and testbench



---
 rtl/will_keen_solitaire_if.sv | 19 +
 rtl/will_keen_solitaire.sv | 175 +++++++++++++++++
 tb/tb_will_keen_solitaire.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/will_keen_solitaire_if.sv
// Tiny Tapeout style pin bundle for the Solitaire keystream tile.
interface will_keen_solitaire_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/will_keen_solitaire.sv
// Solitaire (Pontifex) keystream generator: 54-card register deck, keyed one
// letter at a time, one keystream value per generate request.
module will_keen_solitaire (
  input logic                 clk,
  input logic                 rst,
  will_keen_solitaire_if.slave bus
);

  typedef logic [53:0][5:0] deck_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_A,
    S_MOVE_B,
    S_TRIPLE_CUT,
    S_COUNT_CUT,
    S_KEY_CUT,
    S_OUTPUT
  } state_t;

  state_t     state, state_next;
  deck_t      deck, deck_next;
  logic       mode;
  logic [4:0] letter;
  logic       busy, valid;
  logic [5:0] card;
  logic [4:0] ks;

  logic       start;
  logic [5:0] pos_a, pos_b, a_dst, b_dst, upper, lower;
  logic [5:0] top_v, out_card;
  logic       out_joker;
  logic       unused;

  // Counting value: both jokers count 53.
  function automatic logic [5:0] card_value(logic [5:0] c);
    return (c == 6'd54) ? 6'd53 : c;
  endfunction

  // Lift the card at src out of the deck and reinsert it so it lands at dst.
  function automatic deck_t move_card(deck_t d, logic [5:0] src, logic [5:0] dst);
    deck_t      r;
    logic [5:0] k, kp, km;
    for (int unsigned i = 0; i < 54; i++) begin
      k  = 6'(i);
      kp = 6'((i + 1) % 54);
      km = 6'((i + 53) % 54);
      if (k == dst)                                r[k] = d[src];
      else if (src < dst && k >= src && k < dst)   r[k] = d[kp];
      else if (dst < src && k > dst && k <= src)   r[k] = d[km];
      else                                         r[k] = d[k];
    end
    return r;
  endfunction

  // Swap the block above the upper joker with the block below the lower one.
  function automatic deck_t triple_cut(deck_t d, logic [5:0] p, logic [5:0] q);
    deck_t      r;
    logic [5:0] nb, nm, k;
    nb = 6'd53 - q;
    nm = q - p + 6'd1;
    for (int unsigned i = 0; i < 54; i++) begin
      k = 6'(i);
      if (k < nb)           r[k] = d[q + 6'd1 + k];
      else if (k < nb + nm) r[k] = d[p + k - nb];
      else                  r[k] = d[k - nb - nm];
    end
    return r;
  endfunction

  // Rotate the top 53 cards left by v; the bottom card never moves.
  function automatic deck_t count_cut(deck_t d, logic [5:0] v);
    deck_t      r;
    logic [5:0] k;
    r = d;
    for (int unsigned i = 0; i < 53; i++) begin
      k = 6'(i);
      if (k < 6'd53 - v) r[k] = d[k + v];
      else               r[k] = d[k - (6'd53 - v)];
    end
    return r;
  endfunction

  assign start  = bus.ui_in[7];
  assign unused = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[5]};

  // Locate both jokers and derive their move destinations.
  always_comb begin
    pos_a = '0;
    pos_b = '0;
    for (int unsigned i = 0; i < 54; i++) begin
      if (deck[6'(i)] == 6'd53) pos_a = 6'(i);
      if (deck[6'(i)] == 6'd54) pos_b = 6'(i);
    end
    a_dst = (pos_a == 6'd53) ? 6'd1 : pos_a + 6'd1;
    if (pos_b == 6'd52)      b_dst = 6'd1;
    else if (pos_b == 6'd53) b_dst = 6'd2;
    else                     b_dst = pos_b + 6'd2;
    upper = (pos_a < pos_b) ? pos_a : pos_b;
    lower = (pos_a < pos_b) ? pos_b : pos_a;
    top_v     = card_value(deck[0]);
    out_card  = deck[top_v];
    out_joker = (out_card >= 6'd53);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and next-deck selection.
  always_comb begin
    state_next = state;
    deck_next  = deck;
    case (state)
      S_IDLE:       if (start) state_next = S_MOVE_A;
      S_MOVE_A: begin
        deck_next  = move_card(deck, pos_a, a_dst);
        state_next = S_MOVE_B;
      end
      S_MOVE_B: begin
        deck_next  = move_card(deck, pos_b, b_dst);
        state_next = S_TRIPLE_CUT;
      end
      S_TRIPLE_CUT: begin
        deck_next  = triple_cut(deck, upper, lower);
        state_next = S_COUNT_CUT;
      end
      S_COUNT_CUT: begin
        deck_next  = count_cut(deck, card_value(deck[53]));
        state_next = mode ? S_KEY_CUT : S_OUTPUT;
      end
      S_KEY_CUT: begin
        deck_next  = count_cut(deck, {1'b0, letter});
        state_next = S_IDLE;
      end
      S_OUTPUT:     state_next = out_joker ? S_MOVE_A : S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Deck storage, request latching and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 54; i++) deck[6'(i)] <= 6'(i + 1);
      mode   <= 1'b0;
      letter <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      card   <= '0;
      ks     <= '0;
    end else begin
      deck  <= deck_next;
      valid <= 1'b0;
      if (state == S_IDLE && start) begin
        mode   <= bus.ui_in[6];
        letter <= (bus.ui_in[4:0] == 5'd0 || bus.ui_in[4:0] > 5'd26) ? 5'd26 : bus.ui_in[4:0];
        busy   <= 1'b1;
      end
      if (state == S_KEY_CUT) busy <= 1'b0;
      if (state == S_OUTPUT && !out_joker) begin
        busy  <= 1'b0;
        valid <= 1'b1;
        card  <= out_card;
        ks    <= (out_card <= 6'd26) ? out_card[4:0] : 5'(out_card - 6'd26);
      end
    end
  end

  assign bus.uo_out  = {busy, valid, card};
  assign bus.uio_out = {3'b000, ks};
  assign bus.uio_oe  = 8'h1F;

endmodule

// File: tb/tb_will_keen_solitaire.sv
// Self-checking bench for will_keen_solitaire: known-answer table, hand
// sequences for handshake corners, and random traffic against a deck model.
module tb_will_keen_solitaire;

  logic clk = 1'b0;
  logic rst = 1'b1;
  will_keen_solitaire_if bus();

  will_keen_solitaire dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int valid_count = 0;

  always @(negedge clk) if (bus.uo_out[6] === 1'b1) valid_count++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: deck as a queue ----------------
  int mdeck[$];

  function automatic void model_reset();
    mdeck = {};
    for (int i = 1; i <= 54; i++) mdeck.push_back(i);
  endfunction

  function automatic int cval(int c);
    return (c == 54) ? 53 : c;
  endfunction

  function automatic int find_card(int c);
    int idx = 0;
    foreach (mdeck[i]) if (mdeck[i] == c) idx = i;
    return idx;
  endfunction

  // One step down; a card at the bottom wraps to just below the top card.
  function automatic void m_down_one(int c);
    int idx = find_card(c);
    if (idx == 53) begin
      mdeck.delete(53);
      mdeck.insert(1, c);
    end else begin
      int t;
      t = mdeck[idx + 1];
      mdeck[idx + 1] = c;
      mdeck[idx] = t;
    end
  endfunction

  function automatic void m_triple();
    int a, b, lo, hi;
    int top[$], mid[$], bot[$];
    a = find_card(53);
    b = find_card(54);
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    foreach (mdeck[i]) begin
      if (i < lo)       top.push_back(mdeck[i]);
      else if (i <= hi) mid.push_back(mdeck[i]);
      else              bot.push_back(mdeck[i]);
    end
    mdeck = {bot, mid, top};
  endfunction

  function automatic void m_count(int v);
    int b, t;
    for (int n = 0; n < v; n++) begin
      b = mdeck.pop_back();
      t = mdeck.pop_front();
      mdeck.push_back(t);
      mdeck.push_back(b);
    end
  endfunction

  function automatic void m_round();
    m_down_one(53);
    m_down_one(54);
    m_down_one(54);
    m_triple();
    m_count(cval(mdeck[53]));
  endfunction

  function automatic void m_gen(output int c);
    int v;
    c = 53;
    for (int n = 0; n < 64 && c >= 53; n++) begin
      m_round();
      v = cval(mdeck[0]);
      c = mdeck[v];
    end
  endfunction

  function automatic void m_key(input int l);
    m_round();
    m_count((l == 0 || l > 26) ? 26 : l);
  endfunction

  function automatic int ks_of(int c);
    return ((c - 1) % 26) + 1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ui_in = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_valid(output bit seen);
    int cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.uo_out[6]) seen = 1'b1;
    end
  endtask

  task automatic run_op(input bit m, input int l, input bit rsv,
                        output int card, output int ks);
    int cyc = 0;
    bit ok = 1'b0;
    @(negedge clk);
    bus.ui_in = {1'b1, m, rsv, 5'(l)};
    @(negedge clk);
    bus.ui_in[7] = 1'b0;
    check("busy_rise", int'(bus.uo_out[7]), 1);
    while (!ok && cyc < 2000) begin
      if (!m && bus.uo_out[6]) ok = 1'b1;
      else if (m && !bus.uo_out[7]) ok = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    card = int'(bus.uo_out[5:0]);
    ks   = int'(bus.uio_out[4:0]);
    check(m ? "key_done" : "gen_done", int'(ok), 1);
  endtask

  typedef struct {
    bit do_reset;
    bit mode;
    int letter;
    int exp_card;   // -1: not checked
    int exp_ks;     // -1: not checked
  } vec_t;

  vec_t tbl[18];

  task automatic set_row(input int i, input bit r, input bit m, input int l,
                         input int c, input int k);
    tbl[i] = '{r, m, l, c, k};
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int card, ks, ec, base, last;
    int ref0[3];
    bit seen;

    bus.ena    = 1'b1;
    bus.uio_in = 8'h00;
    bus.ui_in  = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("reset_uo_out", int'(bus.uo_out), 0);
    check("reset_uio_out", int'(bus.uio_out), 0);
    check("reset_uio_oe", int'(bus.uio_oe), 8'h1F);

    // Known-answer table: unkeyed deck, then key "FOO".
    set_row(0, 1, 0, 0, 4, 4);
    set_row(1, 0, 0, 0, 49, 23);
    set_row(2, 0, 0, 0, 10, 10);
    set_row(3, 0, 0, 0, 24, 24);
    set_row(4, 0, 0, 0, 8, 8);
    set_row(5, 0, 0, 0, 51, 25);
    set_row(6, 0, 0, 0, 44, 18);
    set_row(7, 0, 0, 0, 6, 6);
    set_row(8, 0, 0, 0, 4, 4);
    set_row(9, 0, 0, 0, 33, 7);
    set_row(10, 1, 1, 6, -1, -1);
    set_row(11, 0, 1, 15, -1, -1);
    set_row(12, 0, 1, 15, -1, -1);
    set_row(13, 0, 0, 0, -1, 8);
    set_row(14, 0, 0, 0, -1, 19);
    set_row(15, 0, 0, 0, -1, 7);
    set_row(16, 0, 0, 0, -1, 25);
    set_row(17, 0, 0, 0, -1, 20);
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].do_reset) do_reset();
      run_op(tbl[i].mode, tbl[i].letter, 1'b0, card, ks);
      if (tbl[i].exp_card >= 0) check($sformatf("tbl%0d_card", i), card, tbl[i].exp_card);
      if (tbl[i].exp_ks >= 0)   check($sformatf("tbl%0d_ks", i), ks, tbl[i].exp_ks);
    end

    // Start pulses while busy are ignored; one valid per accepted start.
    do_reset();
    base = valid_count;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus.ui_in = 8'h80;
      @(negedge clk); bus.ui_in = 8'h00;
      @(negedge clk); bus.ui_in = 8'h80;
      @(negedge clk); bus.ui_in = 8'h00;
      wait_valid(seen);
      check("busy_start_seen", int'(seen), 1);
      m_gen(ec);
      check("busy_start_card", int'(bus.uo_out[5:0]), ec);
    end
    @(negedge clk);
    check("one_valid_per_start", valid_count - base, 3);

    // Reset in the middle of a generate aborts it.
    do_reset();
    base = valid_count;
    @(negedge clk); bus.ui_in = 8'h80;
    @(negedge clk); bus.ui_in = 8'h00;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    check("midrst_uo_out", int'(bus.uo_out), 0);
    check("midrst_uio_out", int'(bus.uio_out), 0);
    repeat (20) @(negedge clk);
    check("midrst_no_valid", valid_count - base, 0);
    run_op(1'b0, 0, 1'b0, card, ks);
    check("midrst_card", card, 4);
    check("midrst_ks", ks, 4);

    // Start held high: back-to-back operations, outputs hold between pulses.
    do_reset();
    last = 0;
    @(negedge clk); bus.ui_in = 8'h80;
    for (int k = 0; k < 6; k++) begin
      int cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 2000) begin
        @(negedge clk);
        cyc++;
        if (bus.uo_out[6]) seen = 1'b1;
        else if (cyc == 2) check("hold_between", int'(bus.uo_out[5:0]), last);
      end
      check("hold_seen", int'(seen), 1);
      m_gen(ec);
      check("hold_card", int'(bus.uo_out[5:0]), ec);
      check("hold_ks", int'(bus.uio_out[4:0]), ks_of(ec));
      last = ec;
      if (k == 5) bus.ui_in = 8'h00;
      @(negedge clk);
      check("valid_width", int'(bus.uo_out[6]), 0);
      check("restart_busy", int'(bus.uo_out[7]), (k < 5) ? 1 : 0);
      check("uio_oe", int'(bus.uio_oe), 8'h1F);
    end

    // Letter 0 keys exactly like letter 26.
    do_reset();
    run_op(1'b1, 0, 1'b0, card, ks);
    m_key(0);
    for (int k = 0; k < 3; k++) begin
      run_op(1'b0, 0, 1'b0, card, ks);
      m_gen(ec);
      ref0[k] = ec;
      check("key0_card", card, ec);
    end
    do_reset();
    run_op(1'b1, 26, 1'b0, card, ks);
    m_key(26);
    for (int k = 0; k < 3; k++) begin
      run_op(1'b0, 0, 1'b0, card, ks);
      m_gen(ec);
      check("key26_model", ec, ref0[k]);
      check("key26_card", card, ec);
    end

    // Random traffic against the model (letters include 0 and 27..31).
    do_reset();
    for (int n = 0; n < 40; n++) begin
      bit m;
      int l;
      m = ($urandom_range(0, 3) == 0);
      l = int'($urandom_range(0, 31));
      run_op(m, l, 1'($urandom_range(0, 1)), card, ks);
      if (m) m_key(l);
      else begin
        m_gen(ec);
        check("rand_card", card, ec);
        check("rand_ks", ks, ks_of(ec));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
